// File: rtl/riscv_branch_pkg.sv
// Shared definitions for the branch hazard controller: funct3 codes, BHT
// counter encodings, FSM states and the saturating counter update.
package riscv_branch_pkg;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BGE = 3'b101;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } fsm_state_t;

   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != ST) nxt = ctr + 2'd1;
         else           nxt = ctr;
      end else begin
         if (ctr != SNT) nxt = ctr - 2'd1;
         else            nxt = ctr;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch outcome from funct3 and the ALU flags.
module branch_resolve
   import riscv_branch_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       is_greater,
   output logic       taken
);

   // Decode the condition for the supported compare types.
   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = !zero;
         F3_BGE:  taken = is_greater;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch predictor/resolver with PC redirect, flush control and perf counters.
// Prediction (BHT, init sweep, bht_clear) is enabled by BRANCH_PREDICT_EN.
module branch_hazard_ctrl
   import riscv_branch_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_in,
   input  logic             bht_clear,
   input  logic             id_branch,
   input  logic [31:0]      id_pc,
   input  logic [31:0]      id_target,
   output logic             id_pred_taken,
   input  logic             ex_branch,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_target,
   input  logic [2:0]       ex_funct3,
   input  logic             ex_zero,
   input  logic             ex_is_greater,
   input  logic             ex_pred_taken,
   output logic             pc_redirect,
   output logic [31:0]      pc_redirect_addr,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             busy,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   fsm_state_t       state_r;
   logic [CNT_W-1:0] perf_br_r;
   logic [CNT_W-1:0] perf_mp_r;
   logic             taken_s;
   logic             mispredict_s;
   logic             run_s;
   logic             pred_bit_s;
   logic             unused_s;

   branch_resolve u_resolve (
      .funct3     (ex_funct3),
      .zero       (ex_zero),
      .is_greater (ex_is_greater),
      .taken      (taken_s)
   );

   assign mispredict_s = ex_branch & (taken_s != ex_pred_taken);
   assign run_s        = (state_r == RUN);

`ifdef BRANCH_PREDICT_EN
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_ENTRIES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [1:0]       bht_r [BHT_ENTRIES];
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] id_idx_s;
   logic [IDX_W-1:0] ex_idx_s;

   assign id_idx_s   = id_pc[IDX_W+1:2];
   assign ex_idx_s   = ex_pc[IDX_W+1:2];
   assign pred_bit_s = bht_r[id_idx_s][1];
   assign busy       = (state_r == INIT);
   assign unused_s   = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

   // Init sweep / BHT training; the read port sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (state_r == INIT) bht_r[idx_r] <= WNT;
      else if (ex_branch && !stall_in) bht_r[ex_idx_s] <= ctr_update(bht_r[ex_idx_s], taken_s);
   end

   // Sweep index, advancing every cycle regardless of stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_r <= '0;
      end else if (state_r == INIT && !bht_clear && idx_r != IDX_LAST) begin
         idx_r <= idx_r + IDX_ONE;
      end else begin
         idx_r <= '0;
      end
   end
`else
   assign pred_bit_s = 1'b0;
   assign busy       = reset;
   assign unused_s   = ^{id_pc, bht_clear};
`endif

   assign id_pred_taken    = run_s & id_branch & pred_bit_s;
   assign perf_branches    = perf_br_r;
   assign perf_mispredicts = perf_mp_r;

   // Redirect/flush priority: EX mispredict beats an ID predicted-taken branch.
   always_comb begin
      pc_redirect      = 1'b0;
      pc_redirect_addr = 32'd0;
      flush_ifid       = 1'b0;
      flush_idex       = 1'b0;
      if (run_s && !stall_in) begin
         if (mispredict_s) begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = taken_s ? ex_target : (ex_pc + 32'd4);
            flush_ifid       = 1'b1;
            flush_idex       = 1'b1;
         end else if (id_pred_taken) begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = id_target;
            flush_ifid       = 1'b1;
            flush_idex       = 1'b0;
         end else begin
            pc_redirect      = 1'b0;
            pc_redirect_addr = 32'd0;
            flush_ifid       = 1'b0;
            flush_idex       = 1'b0;
         end
      end else begin
         pc_redirect      = 1'b0;
         pc_redirect_addr = 32'd0;
         flush_ifid       = 1'b0;
         flush_idex       = 1'b0;
      end
   end

   // Control FSM and performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= INIT;
         perf_br_r <= '0;
         perf_mp_r <= '0;
      end else begin
         case (state_r)
            INIT: begin
`ifdef BRANCH_PREDICT_EN
               if (!bht_clear && idx_r == IDX_LAST) state_r <= RUN;
               else                                 state_r <= INIT;
`else
               state_r <= RUN;
`endif
            end
            RUN: begin
`ifdef BRANCH_PREDICT_EN
               if (bht_clear) state_r <= INIT;
               else           state_r <= RUN;
`else
               state_r <= RUN;
`endif
               if (ex_branch && !stall_in) begin
                  perf_br_r <= perf_br_r + CNT_W'(1);
                  perf_mp_r <= perf_mp_r + CNT_W'(mispredict_s);
               end
            end
            default: state_r <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed-vector bench with expectation queue and negedge monitor.
module tb_branch_hazard_ctrl;

`ifdef BRANCH_PREDICT_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_in = 1'b0, bht_clear = 1'b0;
   logic        id_branch = 1'b0;
   logic [31:0] id_pc = 32'd0, id_target = 32'd0;
   logic        id_pred_taken;
   logic        ex_branch = 1'b0;
   logic [31:0] ex_pc = 32'd0, ex_target = 32'd0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic        ex_zero = 1'b0, ex_is_greater = 1'b0, ex_pred_taken = 1'b0;
   logic        pc_redirect;
   logic [31:0] pc_redirect_addr;
   logic        flush_ifid, flush_idex, busy;
   logic [31:0] perf_branches, perf_mispredicts;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       nm;
      logic        redir;
      logic [31:0] addr;
      logic        fi, fe, pred, bsy;
      logic [31:0] br, mp;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.BHT_ENTRIES(64), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .stall_in(stall_in), .bht_clear(bht_clear),
      .id_branch(id_branch), .id_pc(id_pc), .id_target(id_target),
      .id_pred_taken(id_pred_taken),
      .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_is_greater(ex_is_greater),
      .ex_pred_taken(ex_pred_taken),
      .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .busy(busy),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
      end
   endtask

   // Monitor: compare every queued expectation against the outputs mid-cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.nm, "pc_redirect", {31'd0, pc_redirect}, {31'd0, e.redir});
         chk(e.nm, "redirect_addr", pc_redirect_addr, e.addr);
         chk(e.nm, "flush_ifid", {31'd0, flush_ifid}, {31'd0, e.fi});
         chk(e.nm, "flush_idex", {31'd0, flush_idex}, {31'd0, e.fe});
         chk(e.nm, "id_pred_taken", {31'd0, id_pred_taken}, {31'd0, e.pred});
         chk(e.nm, "busy", {31'd0, busy}, {31'd0, e.bsy});
         chk(e.nm, "perf_branches", perf_branches, e.br);
         chk(e.nm, "perf_mispredicts", perf_mispredicts, e.mp);
      end
   end

   // Drive one cycle of stimulus just after the edge and queue its expectation.
   task automatic step(input string nm,
                       input logic eb, input logic [2:0] f3, input logic z, input logic gt,
                       input logic pr, input logic [31:0] epc, input logic [31:0] etg,
                       input logic ib, input logic [31:0] ipc, input logic [31:0] itg,
                       input logic st, input logic clr,
                       input logic e_redir, input logic [31:0] e_addr,
                       input logic e_fi, input logic e_fe, input logic e_pred, input logic e_busy,
                       input logic [31:0] e_br, input logic [31:0] e_mp);
      exp_t e;
      @(posedge clk);
      #1;
      ex_branch = eb; ex_funct3 = f3; ex_zero = z; ex_is_greater = gt; ex_pred_taken = pr;
      ex_pc = epc; ex_target = etg;
      id_branch = ib; id_pc = ipc; id_target = itg;
      stall_in = st; bht_clear = clr;
      e.nm = nm; e.redir = e_redir; e.addr = e_addr; e.fi = e_fi; e.fe = e_fe;
      e.pred = e_pred; e.bsy = e_busy; e.br = e_br; e.mp = e_mp;
      exp_q.push_back(e);
   endtask

   task automatic count_busy(input string nm, input int req);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy) cnt++;
         else break;
      end
      chk(nm, "busy_cycles", cnt, req);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held: mispredict-looking EX must be ignored, busy high.
      step("reset0", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      step("reset1", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      count_busy("init_sweep", PE ? 64 : 0);

      step("idle", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step("beq_mis", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++)
         step("bne_taken", 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h40, 32'h300, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
              1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1 + i, 32'd1 + i);
      step("id_pred", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h40, 32'h500, 1'b0, 1'b0,
           PE, PE ? 32'h500 : 32'd0, PE, 1'b0, PE, 1'b0, 32'd4, 32'd4);
      step("ex_over_id", 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h200, 32'h80, 1'b1, 32'h40, 32'h500, 1'b0, 1'b0,
           1'b1, 32'h204, 1'b1, 1'b1, PE, 1'b0, 32'd4, 32'd4);
      step("bge_ok", 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 32'h300, 32'h600, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5);
      for (int i = 0; i < 2; i++)
         step("stall_hold", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0,
              1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6, 32'd5);
      step("stall_release", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd5);
      step("f3_010", 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6);
      step("counts", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8, 32'd6);
      step("bht_clear", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8, 32'd6);
      @(posedge clk);
      #1 bht_clear = 1'b0;
      count_busy("clear_sweep", PE ? 64 : 0);
      step("pred_after_clear", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h40, 32'h500, 1'b0, 1'b0,
           1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8, 32'd6);

      @(posedge clk);
      #1 id_branch = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("drain", "queue_left", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
